// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg
//   Shared definitions for the multi-cycle shift sequencer and its
//   single-bit shifter stage: the 2-bit shifter control encoding and the
//   sequencer state encoding.
package shift_sequencer_pkg;

    // Control word applied to nBitShifter.c
    localparam logic [1:0] SH_LEFT  = 2'b00;  // shift left 1, LSB <- 0
    localparam logic [1:0] SH_PASS  = 2'b01;  // pass through
    localparam logic [1:0] SH_RIGHT = 2'b10;  // logical shift right 1, MSB <- 0
    localparam logic [1:0] SH_ZERO  = 2'b11;  // force all zeros

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_nbitshifter.sv
// nBitShifter
//   Combinational single-position shifter stage.
// Ports:
//   Fout  in  n  value to be shifted (the sequencer's working register)
//   c     in  2  control: 00 left, 01 pass, 10 logical right, 11 zero
//   F     out n  shifted result
module nBitShifter
    import shift_sequencer_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] Fout,
    input  logic [1:0]   c,
    output logic [n-1:0] F
);

    always_comb begin
        F = '0;
        case (c)
            SH_LEFT:  F = {Fout[n-2:0], 1'b0};
            SH_PASS:  F = Fout;
            SH_RIGHT: F = {1'b0, Fout[n-1:1]};
            default:  F = '0;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Drives a single-bit shifter once per cycle, feeding its output back into
//   a working register until the requested shift amount is reached, then
//   presents the result on a registered port with a one-cycle done pulse.
// Ports:
//   clk         in  1   rising-edge clock
//   rst_n       in  1   asynchronous active-low reset
//   start       in  1   request, sampled only while idle
//   din         in  N   operand, captured on an accepted start
//   amt         in  AW  unsigned shift amount, captured with din
//   dir         in  1   0 = left, 1 = logical right, captured with din
//   busy        out 1   high while shifting or presenting the result
//   done        out 1   one-cycle pulse, dout valid in the same cycle
//   dout        out N   result register, held until the next done
//   shift_ctrl  out 2   control currently applied to the shifter
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  din,
    input  logic [AW-1:0] amt,
    input  logic          dir,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  dout,
    output logic [1:0]    shift_ctrl
);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  work;
    logic [N-1:0]  work_next;
    logic [N-1:0]  shifted;
    logic [AW-1:0] cnt;
    logic          shift_right;
    logic          zfill;
    logic          accept;

    assign accept = (state == S_IDLE) && start;

    nBitShifter #(
        .n (N)
    ) u_shifter (
        .Fout (work),
        .c    (shift_ctrl),
        .F    (shifted)
    );

    // The shifter output is the next working value, except on the accept
    // edge where the operand is loaded instead.
    assign work_next = accept ? din : shifted;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and shifter control decode; control depends only on
    // registered state so there is no input-to-output path.
    always_comb begin
        state_next = state;
        shift_ctrl = SH_PASS;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (zfill) begin
                    shift_ctrl = SH_ZERO;
                end else begin
                    shift_ctrl = shift_right ? SH_RIGHT : SH_LEFT;
                end
                if (zfill || (cnt == AW'(1))) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Working register, counter, captured controls and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work        <= '0;
            cnt         <= '0;
            shift_right <= 1'b0;
            zfill       <= 1'b0;
            dout        <= '0;
        end else begin
            work <= work_next;
            if (accept) begin
                cnt         <= amt;
                shift_right <= dir;
                // Any shift of N or more positions clears the operand, so it
                // is done in one zeroing step instead of amt shifts.
                zfill       <= (32'(amt) >= N);
            end else if ((state == S_SHIFT) && !zfill) begin
                cnt <= cnt - AW'(1);
            end
            // work is overwritten on this same edge, so capture the value it
            // is about to take (the final shift result, or din when amt==0).
            if (state_next == S_DONE) begin
                dout <= work_next;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  din;
    logic [AW-1:0] amt;
    logic          dir;
    logic          busy;
    logic          done;
    logic [N-1:0]  dout;
    logic [1:0]    shift_ctrl;

    int tests = 0;
    int fails = 0;

    shift_sequencer #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .amt        (amt),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .shift_ctrl (shift_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [N-1:0]  din;
        logic [AW-1:0] amt;
        logic          dir;
        logic [1:0]    ctrl1;   // shift_ctrl expected in cycle 1
        int            lat;     // cycle in which done is expected
        logic [N-1:0]  dout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        logic [N-1:0] res;
        @(negedge clk);
        din = v.din; amt = v.amt; dir = v.dir; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // inputs may change freely after the capture edge
        din = ~v.din; amt = ~v.amt; dir = ~v.dir;
        check({tag, "_ctrl1"}, 32'(shift_ctrl), 32'(v.ctrl1));
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.lat));
        check({tag, "_dout"}, 32'(dout), 32'(v.dout));
        res = dout;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_dout_hold"}, 32'(dout), 32'(res));
    endtask

    initial begin
        //          din      amt   dir   ctrl1  lat dout
        vecs[0] = '{4'b1011, 3'd1, 1'b0, 2'b00, 2, 4'b0110};
        vecs[1] = '{4'b1011, 3'd2, 1'b1, 2'b10, 3, 4'b0010};
        vecs[2] = '{4'b1011, 3'd0, 1'b0, 2'b01, 1, 4'b1011};
        vecs[3] = '{4'b1011, 3'd5, 1'b0, 2'b11, 2, 4'b0000};
        vecs[4] = '{4'b0001, 3'd3, 1'b0, 2'b00, 4, 4'b1000};
        vecs[5] = '{4'b1000, 3'd3, 1'b1, 2'b10, 4, 4'b0001};
        vecs[6] = '{4'b0110, 3'd4, 1'b1, 2'b11, 2, 4'b0000};
        vecs[7] = '{4'b1111, 3'd7, 1'b1, 2'b11, 2, 4'b0000};
        vecs[8] = '{4'b0101, 3'd2, 1'b0, 2'b00, 3, 4'b0100};

        rst_n = 1'b0; start = 1'b0; din = '0; amt = '0; dir = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ctrl", 32'(shift_ctrl), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle%0d_done", i), 32'(done), 32'd0);
            check($sformatf("idle%0d_busy", i), 32'(busy), 32'd0);
            check($sformatf("idle%0d_dout", i), 32'(dout), 32'd0);
            check($sformatf("idle%0d_ctrl", i), 32'(shift_ctrl), 32'd1);
        end

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed during SHIFT is ignored
        begin
            int lat;
            @(negedge clk);
            din = 4'b1001; amt = 3'd3; dir = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            din = 4'b1111; amt = 3'd0; dir = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("ign_busy2", 32'(busy), 32'd1);
            check("ign_ctrl2", 32'(shift_ctrl), 32'd0);
            lat = 2;
            while (!done && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check("ign_lat", 32'(lat), 32'd4);
            check("ign_dout", 32'(dout), 32'b1000);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check($sformatf("ign_done_after%0d", k), 32'(done), 32'd0);
                check($sformatf("ign_dout_after%0d", k), 32'(dout), 32'b1000);
            end
        end

        // reset in the middle of an operation
        begin
            int seen_done;
            seen_done = 0;
            @(negedge clk);
            din = 4'b1011; amt = 3'd3; dir = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            check("midrst_dout", 32'(dout), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_ctrl", 32'(shift_ctrl), 32'd1);
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (done) seen_done++;
            end
            check("midrst_no_done", 32'(seen_done), 32'd0);
            check("midrst_dout_after", 32'(dout), 32'd0);
        end
        run_op(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
